// File: rtl/shift_reg_seq_ctrl.sv
// Full-duplex serializer/deserializer sequencer: accepts a parallel word,
// shifts it out over WIDTH cycles while capturing sin, then pulses done.
module shift_reg_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic             sout,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               dir_q;

  always_comb begin
    shreg_nxt = shreg;
    if (dir_q) shreg_nxt = {sin, shreg[WIDTH-1:1]};
    else       shreg_nxt = {shreg[WIDTH-2:0], sin};
  end

  // shift_en is a registered copy of (state == SHIFT), so it gates sout directly
  assign sout = shift_en & (dir_q ? shreg[0] : shreg[WIDTH-1]);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      dir_q       <= 1'b0;
      dout        <= '0;
      done        <= 1'b0;
      shift_en    <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            shreg       <= din;
            dir_q       <= dir;
            cnt         <= '0;
            state       <= SHIFT;
            shift_en    <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            dout     <= shreg_nxt;
            state    <= DONE;
            shift_en <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          done        <= 1'b0;
          shift_en    <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
